// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: synchronizes and debounces panel/interlock inputs, then runs the
// IDLE/COOK/PAUSED FSM that owns the registered magnetron enable Q.
module magnetron_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_done,
    input  logic       door_closed,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    output logic       Q,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, COOK = 2'b01, PAUSED = 2'b10} state_t;
    localparam logic [4:0] RST_VAL = 5'b11100;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [4:0] raw, filt;
    logic       start_d, start, clr, stp, open, tdone;
    logic [1:0] st;
    state_t     next;
    assign raw = {stopn, startn, clearn, door_closed, timer_done};
    for (genvar i = 0; i < 5; i++) begin : g_in
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt;
        logic                   f;
        logic                   s;
        assign s       = sync[SYNC_STAGES-1];
        assign filt[i] = f;
        // filtered value flips only after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge clk) begin
            if (rst) begin
                sync <= {SYNC_STAGES{RST_VAL[i]}};
                cnt  <= '0;
                f    <= RST_VAL[i];
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], raw[i]};
                cnt  <= (s == f || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                f    <= (s != f && cnt == CNT_MAX) ? s : f;
            end
        end
    end
    assign tdone = filt[0];
    assign open  = !filt[1];
    assign clr   = !filt[2];
    assign stp   = !filt[4];
    assign start = start_d && !filt[3];
    always_ff @(posedge clk) begin
        if (rst) begin
            start_d <= 1'b1;
            st      <= IDLE;
            Q       <= 1'b0;
        end else begin
            start_d <= filt[3];
            st      <= next;
            Q       <= next == COOK;
        end
    end
    always_comb begin
        next = IDLE;
        case (st)
            IDLE:    next = (start && !clr && !stp && !open && !tdone) ? COOK : IDLE;
            COOK:    next = (clr || tdone) ? IDLE : (open || stp) ? PAUSED : COOK;
            PAUSED:  next = clr ? IDLE : (start && !stp && !open && !tdone) ? COOK : PAUSED;
            default: next = IDLE;
        endcase
    end
    assign state = st;
endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb_magnetron_ctrl: directed checks of {Q,state} for magnetron_ctrl.
module tb_magnetron_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       timer_done = 1'b0, door_closed = 1'b0, clearn = 1'b1, startn = 1'b1, stopn = 1'b1;
    logic       Q;
    logic [1:0] state;
    int         checks = 0, failures = 0;

    localparam logic [2:0] S_IDLE = 3'b000, S_COOK = 3'b101, S_PAUSED = 3'b010;

    magnetron_ctrl dut (
        .clk(clk), .rst(rst), .timer_done(timer_done), .door_closed(door_closed),
        .clearn(clearn), .startn(startn), .stopn(stopn), .Q(Q), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] exp);
        checks++;
        assert ({Q, state} === exp) else begin
            failures++;
            $error("FAIL %s observed Q/state=%b expected=%b", tag, {Q, state}, exp);
        end
    endtask

    initial begin
        step(3);
        chk("reset", S_IDLE);
        rst = 1'b0;
        door_closed = 1'b1;
        startn = 1'b0;
        step(6);
        chk("start_lat6", S_IDLE);
        step(1);
        chk("start_lat7", S_COOK);
        startn = 1'b1;
        step(100);
        chk("cook_hold100", S_COOK);
        startn = 1'b0;
        step(10);
        chk("start_in_cook", S_COOK);
        timer_done = 1'b1;
        step(6);
        chk("tdone_lat6", S_COOK);
        step(1);
        chk("tdone_lat7", S_IDLE);
        timer_done = 1'b0;
        step(20);
        chk("no_new_edge", S_IDLE);
        startn = 1'b1;
        step(10);
        startn = 1'b0;
        step(7);
        chk("recook", S_COOK);
        door_closed = 1'b0;
        step(6);
        chk("door_lat6", S_COOK);
        step(1);
        chk("door_open", S_PAUSED);
        door_closed = 1'b1;
        startn = 1'b1;
        step(10);
        chk("door_closed_wait", S_PAUSED);
        startn = 1'b0;
        step(7);
        chk("resume", S_COOK);
        stopn = 1'b0;
        step(7);
        chk("stop", S_PAUSED);
        startn = 1'b1;
        step(10);
        startn = 1'b0;
        step(10);
        chk("start_while_stop", S_PAUSED);
        stopn = 1'b1;
        step(10);
        chk("stop_release", S_PAUSED);
        clearn = 1'b0;
        step(7);
        chk("clear_paused", S_IDLE);
        clearn = 1'b1;
        startn = 1'b1;
        step(10);
        clearn = 1'b0;
        startn = 1'b0;
        step(10);
        chk("clear_and_start", S_IDLE);
        clearn = 1'b1;
        startn = 1'b1;
        step(10);
        startn = 1'b0;
        step(2);
        startn = 1'b1;
        step(20);
        chk("glitch2", S_IDLE);
        startn = 1'b0;
        step(3);
        startn = 1'b1;
        step(20);
        chk("glitch3", S_IDLE);
        startn = 1'b0;
        step(4);
        startn = 1'b1;
        step(20);
        chk("press4", S_COOK);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_cook", S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        step(10);
        force dut.st = 2'b11;
        step(1);
        chk("forced_11", 3'b011);
        @(negedge clk);
        release dut.st;
        @(posedge clk);
        #1;
        chk("unused_recover", S_IDLE);
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
